// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester and
// the data (load/store) requester. One transaction is in flight at a time;
// data wins ties so a stalled load/store never waits behind a fetch.
// Optional feature macro: ARB_FAIRNESS_EN -- after STARVE_LIMIT consecutive
// data grants made while a fetch waits, the next grant goes to the fetch.
// Without the macro the arbiter uses strict data priority.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              arb_busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t state;
   logic   sel_d;
   logic   grant_d;
   logic   grant_if;
   logic   starve_hit;

   // A zero starvation limit would make the fairness rule meaningless.
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_FAIRNESS_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   // The waiting fetch has been passed over often enough: it takes the next grant.
   assign starve_hit = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
   assign starve_hit = 1'b0;
`endif

   // Grant selection in IDLE: data first unless the fetch is being starved.
   assign grant_d  = d_req && !starve_hit;
   assign grant_if = if_req && !grant_d;

   // Arbitration FSM; every output, the owner bit and the captured read data
   // are registered here so the memory and both requesters see clean levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel_d     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         arb_busy  <= 1'b0;
`ifdef ARB_FAIRNESS_EN
         starve_cnt <= '0;
`endif
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d || grant_if) begin
                  sel_d     <= grant_d;
                  mem_we    <= grant_d ? d_we : 1'b0;
                  mem_addr  <= grant_d ? d_addr : if_addr;
                  mem_wdata <= grant_d ? d_wdata : '0;
                  mem_req   <= 1'b1;
                  arb_busy  <= 1'b1;
                  state     <= BUSY;
`ifdef ARB_FAIRNESS_EN
                  if (grant_d && if_req) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end else begin
                     starve_cnt <= '0;
                  end
`endif
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  if (sel_d) begin
                     if (!mem_we) begin
                        d_rdata <= mem_rdata;
                     end
                     d_ack <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               arb_busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               mem_req  <= 1'b0;
               arb_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: a table of single transactions,
// hand-written corner-case sequences, and a randomized run checked against a
// transaction-level timing model. Honours ARB_FAIRNESS_EN like the design.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              arb_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Memory behaviour knobs set by the test, plus expected held read data.
   int          mem_wait  = 0;
   logic [31:0] mem_val   = '0;
   int          spur_mode = 0;
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_d_rd  = '0;

   typedef struct {
      string       name;
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      int          exp_ack_cycle;
      int          exp_mem_cycles;
      logic [31:0] exp_rdata;
   } vec_t;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_rdata(if_rdata),
      .if_ack(if_ack),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_rdata(d_rdata),
      .d_ack(d_ack),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack),
      .arb_busy(arb_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Memory model: acks after mem_wait extra cycles of mem_req, optionally
   // throws spurious acks while no request is pending.
   bit in_txn   = 1'b0;
   int busy_cnt = 0;
   int txn_wait = 0;
   always @(posedge clk) begin
      #2;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
         if (!in_txn) begin
            in_txn   = 1'b1;
            txn_wait = mem_wait;
            busy_cnt = 0;
         end
         if (busy_cnt == txn_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_val;
            in_txn    = 1'b0;
         end else begin
            busy_cnt++;
         end
      end else begin
         in_txn = 1'b0;
         if (spur_mode == 1 || (spur_mode == 2 && $urandom_range(3) == 0)) begin
            mem_ack = 1'b1;
         end
      end
   end

   // Hard stop if something wedges the run.
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, wanted completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
      checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      checkOutput({tag, "_if_ack"}, {31'b0, if_ack}, 32'h0);
      checkOutput({tag, "_d_ack"}, {31'b0, d_ack}, 32'h0);
      checkOutput({tag, "_if_rdata"}, if_rdata, 32'h0);
      checkOutput({tag, "_d_rdata"}, d_rdata, 32'h0);
      checkOutput({tag, "_arb_busy"}, {31'b0, arb_busy}, 32'h0);
   endtask

   task automatic doReset(input string tag);
      if_req = 1'b0;
      d_req  = 1'b0;
      rst    = 1'b1;
      #2;
      checkAllZero(tag);
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_if_rd = '0;
      exp_d_rd  = '0;
   endtask

   function automatic vec_t mkVec(input string name, input bit is_d, input bit we,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int waits,
                                  input int ack_c, input int mem_c,
                                  input logic [31:0] exp_rd);
      vec_t v;
      v.name           = name;
      v.is_d           = is_d;
      v.we             = we;
      v.addr           = addr;
      v.wdata          = wdata;
      v.rdata          = rdata;
      v.waits          = waits;
      v.exp_ack_cycle  = ack_c;
      v.exp_mem_cycles = mem_c;
      v.exp_rdata      = exp_rd;
      return v;
   endfunction

   // One isolated transaction: request raised in cycle 0, DUT observed
   // each following cycle until the owner's ack appears.
   task automatic applyStimulus(input vec_t v);
      int   mem_cyc;
      int   ack_cyc;
      logic own_ack;
      logic oth_ack;
      mem_wait = v.waits;
      mem_val  = v.rdata;
      if (v.is_d) begin
         d_req   = 1'b1;
         d_we    = v.we;
         d_addr  = v.addr;
         d_wdata = v.wdata;
      end else begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end
      mem_cyc = 0;
      ack_cyc = -1;
      for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
         stepCycle();
         if (mem_req) begin
            mem_cyc++;
            checkOutput({v.name, "_mem_addr"}, mem_addr, v.addr);
            checkOutput({v.name, "_mem_we"}, {31'b0, mem_we}, {31'b0, v.we});
            if (v.we) begin
               checkOutput({v.name, "_mem_wdata"}, mem_wdata, v.wdata);
            end
         end
         own_ack = v.is_d ? d_ack : if_ack;
         oth_ack = v.is_d ? if_ack : d_ack;
         checkOutput({v.name, "_other_ack"}, {31'b0, oth_ack}, 32'h0);
         if (own_ack) begin
            ack_cyc = c;
            if (v.is_d) d_req = 1'b0;
            else        if_req = 1'b0;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      checkOutput({v.name, "_ack_cycle"}, ack_cyc, v.exp_ack_cycle);
      checkOutput({v.name, "_mem_cycles"}, mem_cyc, v.exp_mem_cycles);
      if (v.is_d) begin
         checkOutput({v.name, "_d_rdata"}, d_rdata, v.exp_rdata);
         checkOutput({v.name, "_if_rdata_held"}, if_rdata, exp_if_rd);
         exp_d_rd = v.exp_rdata;
      end else begin
         checkOutput({v.name, "_if_rdata"}, if_rdata, v.exp_rdata);
         checkOutput({v.name, "_d_rdata_held"}, d_rdata, exp_d_rd);
         exp_if_rd = v.exp_rdata;
      end
      stepCycle();
      checkOutput({v.name, "_idle_busy"}, {31'b0, arb_busy}, 32'h0);
      checkOutput({v.name, "_idle_mem_req"}, {31'b0, mem_req}, 32'h0);
   endtask

   // Both requesters raise at once: store first, then the fetch.
   task automatic runSimultaneous();
      mem_wait = 0;
      mem_val  = 32'h24020001;
      if_req   = 1'b1;
      if_addr  = 32'h00400008;
      d_req    = 1'b1;
      d_we     = 1'b1;
      d_addr   = 32'h10010000;
      d_wdata  = 32'h1234ABCD;
      stepCycle();
      checkOutput("sim_c1_mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("sim_c1_mem_we", {31'b0, mem_we}, 32'h1);
      checkOutput("sim_c1_mem_addr", mem_addr, 32'h10010000);
      checkOutput("sim_c1_mem_wdata", mem_wdata, 32'h1234ABCD);
      checkOutput("sim_c1_busy", {31'b0, arb_busy}, 32'h1);
      stepCycle();
      checkOutput("sim_c2_d_ack", {31'b0, d_ack}, 32'h1);
      checkOutput("sim_c2_if_ack", {31'b0, if_ack}, 32'h0);
      checkOutput("sim_c2_mem_req", {31'b0, mem_req}, 32'h0);
      d_req = 1'b0;
      stepCycle();
      checkOutput("sim_c3_busy", {31'b0, arb_busy}, 32'h0);
      checkOutput("sim_c3_acks", {30'b0, if_ack, d_ack}, 32'h0);
      stepCycle();
      checkOutput("sim_c4_mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("sim_c4_mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("sim_c4_mem_addr", mem_addr, 32'h00400008);
      stepCycle();
      checkOutput("sim_c5_if_ack", {31'b0, if_ack}, 32'h1);
      checkOutput("sim_c5_if_rdata", if_rdata, 32'h24020001);
      checkOutput("sim_c5_d_rdata_held", d_rdata, exp_d_rd);
      exp_if_rd = 32'h24020001;
      if_req = 1'b0;
      stepCycle();
      checkOutput("sim_c6_busy", {31'b0, arb_busy}, 32'h0);
   endtask

   // Memory acks with nothing pending must be ignored.
   task automatic runSpurious();
      spur_mode = 1;
      for (int c = 0; c < 8; c++) begin
         stepCycle();
         checkOutput($sformatf("spur%0d_busy", c), {31'b0, arb_busy}, 32'h0);
         checkOutput($sformatf("spur%0d_mem_req", c), {31'b0, mem_req}, 32'h0);
         checkOutput($sformatf("spur%0d_acks", c), {30'b0, if_ack, d_ack}, 32'h0);
         checkOutput($sformatf("spur%0d_if_rdata", c), if_rdata, exp_if_rd);
         checkOutput($sformatf("spur%0d_d_rdata", c), d_rdata, exp_d_rd);
      end
      spur_mode = 0;
      stepCycle();
   endtask

   // Reset in the middle of a long memory wait abandons the load silently.
   task automatic runResetBusy();
      mem_wait = 50;
      mem_val  = 32'hBADBAD00;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h10010008;
      for (int c = 1; c <= 3; c++) begin
         stepCycle();
         checkOutput($sformatf("rstb_c%0d_mem_req", c), {31'b0, mem_req}, 32'h1);
      end
      rst = 1'b1;
      #2;
      checkAllZero("rst_busy");
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_if_rd = '0;
      exp_d_rd  = '0;
      mem_wait  = 0;
      for (int c = 0; c < 10; c++) begin
         stepCycle();
         checkOutput($sformatf("rsta%0d_d_ack", c), {31'b0, d_ack}, 32'h0);
         checkOutput($sformatf("rsta%0d_mem_req", c), {31'b0, mem_req}, 32'h0);
      end
      applyStimulus(mkVec("post_rst_fetch", 1'b0, 1'b0, 32'h00400020, 32'h0,
                          32'h3C011001, 1, 3, 2, 32'h3C011001));
   endtask

   // Data requester never lets go while a fetch waits.
   task automatic runFairness();
      int grants;
      bit prev_req;
      bit is_fetch;
      bit exp_fetch;
      grants   = 0;
      prev_req = 1'b0;
      mem_wait = 0;
      mem_val  = 32'h0;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h10010010;
      if_req   = 1'b1;
      if_addr  = 32'h00400010;
      for (int c = 0; c < 120 && grants < 10; c++) begin
         stepCycle();
         if (mem_req && !prev_req) begin
            is_fetch  = (mem_addr == 32'h00400010);
            exp_fetch = FAIR && ((grants % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
            checkOutput($sformatf("fair_grant%0d_is_fetch", grants),
                        {31'b0, is_fetch}, {31'b0, exp_fetch});
            grants++;
         end
         prev_req = mem_req;
      end
      checkOutput("fair_grant_count", grants, 10);
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (8) stepCycle();
   endtask

   // Randomized traffic against a timing model: a grant in cycle g with w
   // memory wait states means mem_req in g+1..g+1+w, ack in g+2+w and the
   // arbiter free again from g+3+w.
   task automatic runRandom(input int ncycles);
      bit          act;
      int          g;
      int          w;
      bit          own_d;
      bit          own_we;
      logic [31:0] own_addr;
      logic [31:0] own_wdata;
      logic [31:0] own_val;
      int          starve;
      bit          ack_now;
      bit          req_e;
      bit          busy_e;
      bit          idle;
      bit          dropped_if;
      bit          dropped_d;
      bit          hit;
      act       = 1'b0;
      g         = 0;
      w         = 0;
      own_d     = 1'b0;
      own_we    = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      own_val   = '0;
      starve    = 0;
      spur_mode = 2;
      for (int k = 0; k < ncycles; k++) begin
         stepCycle();
         ack_now = act && (k == g + 2 + w);
         req_e   = act && (k >= g + 1) && (k <= g + 1 + w);
         busy_e  = act && (k >= g + 1) && (k <= g + 2 + w);
         if (ack_now) begin
            if (!own_d)      exp_if_rd = own_val;
            else if (!own_we) exp_d_rd = own_val;
         end
         checkOutput("rnd_mem_req", {31'b0, mem_req}, {31'b0, req_e});
         checkOutput("rnd_arb_busy", {31'b0, arb_busy}, {31'b0, busy_e});
         checkOutput("rnd_if_ack", {31'b0, if_ack}, {31'b0, ack_now && !own_d});
         checkOutput("rnd_d_ack", {31'b0, d_ack}, {31'b0, ack_now && own_d});
         checkOutput("rnd_if_rdata", if_rdata, exp_if_rd);
         checkOutput("rnd_d_rdata", d_rdata, exp_d_rd);
         if (req_e) begin
            checkOutput("rnd_mem_addr", mem_addr, own_addr);
            checkOutput("rnd_mem_we", {31'b0, mem_we}, {31'b0, own_we});
            if (own_we) begin
               checkOutput("rnd_mem_wdata", mem_wdata, own_wdata);
            end
         end
         dropped_if = 1'b0;
         dropped_d  = 1'b0;
         if (ack_now) begin
            if (own_d) begin
               d_req     = 1'b0;
               dropped_d = 1'b1;
            end else begin
               if_req     = 1'b0;
               dropped_if = 1'b1;
            end
         end
         if (!if_req && !dropped_if && $urandom_range(2) == 0) begin
            if_req  = 1'b1;
            if_addr = {$urandom_range(32'h3FFFFFFF), 2'b00};
         end
         if (!d_req && !dropped_d && $urandom_range(2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_addr  = {$urandom_range(32'h3FFFFFFF), 2'b00};
            d_wdata = $urandom;
         end
         idle = !act || (k >= g + 3 + w);
         if (idle && (if_req || d_req)) begin
            hit = FAIR && if_req && (starve == STARVE_LIMIT);
            if (d_req && !hit) begin
               own_d     = 1'b1;
               own_we    = d_we;
               own_addr  = d_addr;
               own_wdata = d_wdata;
               starve    = if_req ? starve + 1 : 0;
            end else begin
               own_d     = 1'b0;
               own_we    = 1'b0;
               own_addr  = if_addr;
               own_wdata = '0;
               starve    = 0;
            end
            act      = 1'b1;
            g        = k;
            w        = $urandom_range(3);
            own_val  = $urandom;
            mem_wait = w;
            mem_val  = own_val;
         end else if (idle) begin
            act = 1'b0;
         end
      end
      spur_mode = 0;
      if_req    = 1'b0;
      d_req     = 1'b0;
   endtask

   initial begin
      vec_t vecs[5];
      vecs[0] = mkVec("fetch_zw", 1'b0, 1'b0, 32'h00400000, 32'h0, 32'h20080005,
                      0, 2, 1, 32'h20080005);
      vecs[1] = mkVec("load_w4", 1'b1, 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF,
                      4, 6, 5, 32'hDEADBEEF);
      vecs[2] = mkVec("store_w1", 1'b1, 1'b1, 32'h10010000, 32'h1234ABCD, 32'h55555555,
                      1, 3, 2, 32'hDEADBEEF);
      vecs[3] = mkVec("fetch_w2", 1'b0, 1'b0, 32'h00400004, 32'h0, 32'h8C890000,
                      2, 4, 3, 32'h8C890000);
      vecs[4] = mkVec("load_top", 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF,
                      0, 2, 1, 32'hFFFFFFFF);

      #1;
      $display("[TB] reset and directed transactions");
      doReset("reset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] simultaneous requests");
      runSimultaneous();

      $display("[TB] spurious memory acks while idle");
      runSpurious();

      $display("[TB] reset during a busy transaction");
      runResetBusy();

      $display("[TB] continuous data traffic with a waiting fetch");
      runFairness();

      $display("[TB] randomized traffic");
      doReset("reset_rnd");
      runRandom(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
